// File: rtl/pipe_stall_ctrl_if.sv
// Hazard-to-pipeline control bundle: request inputs from hazard sources,
// stall/bubble/flush strobes and statistics back out to the pipeline.
interface pipe_stall_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             bbl_req;
  logic             stop_req;
  logic             flush_req;
  logic [5:0]       stall;
  logic             bubble;
  logic             flush;
  logic             timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output bbl_req, stop_req, flush_req,
    input  stall, bubble, flush, timeout, stall_cycles
  );

  modport slave (
    input  bbl_req, stop_req, flush_req,
    output stall, bubble, flush, timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: prioritises stop > flush > bubble into per-stage
// hold enables, NOP injection and front-end flush, with a stall watchdog.
module pipe_stall_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stall_ctrl_if.slave io_bus
);
  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;

  localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] WD_LIMIT   = 16'(TIMEOUT);
  localparam logic [5:0]  STALL_STOP = 6'b011111;
  localparam logic [5:0]  STALL_BBL  = 6'b000011;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_flush_cnt, w_flush_cnt_nxt;
  logic             r_flush_pend, w_flush_pend_nxt;
  logic [15:0]      r_wd_cnt, w_wd_nxt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [5:0]       w_stall;
  logic             w_bubble, w_flush, w_flush_any, w_stalled;

  assign w_flush_any = io_bus.flush_req | r_flush_pend | (r_state == FLUSH);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_state_nxt      = r_state;
    w_flush_cnt_nxt  = r_flush_cnt;
    w_flush_pend_nxt = r_flush_pend;
    w_stall          = '0;
    w_bubble         = 1'b0;
    w_flush          = 1'b0;
    if (io_bus.stop_req) begin
      // Any flush seen while stopped is deferred until the unit releases.
      w_stall     = STALL_STOP;
      w_state_nxt = HOLD;
      if (w_flush_any) w_flush_pend_nxt = 1'b1;
    end else if (w_flush_any) begin
      w_flush = 1'b1;
      if (io_bus.flush_req || (r_state != FLUSH)) begin
        w_flush_cnt_nxt  = FLUSH_LOAD;
        w_flush_pend_nxt = 1'b0;
        w_state_nxt      = (FLUSH_LOAD == 4'd0) ? RUN : FLUSH;
      end else if (r_flush_cnt <= 4'd1) begin
        w_flush_cnt_nxt = 4'd0;
        w_state_nxt     = RUN;
      end else begin
        w_flush_cnt_nxt = r_flush_cnt - 4'd1;
      end
    end else begin
      w_state_nxt = RUN;
      if (io_bus.bbl_req) begin
        w_stall  = STALL_BBL;
        w_bubble = 1'b1;
      end
    end
  end

  assign w_stalled = |w_stall;
  assign w_wd_nxt  = !w_stalled               ? 16'd0 :
                     (r_wd_cnt == WD_LIMIT)   ? r_wd_cnt :
                                                r_wd_cnt + 16'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= RUN;
      r_flush_cnt    <= 4'd0;
      r_flush_pend   <= 1'b0;
      r_wd_cnt       <= 16'd0;
      r_timeout      <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops see pre-edge values.
      r_state      <= w_state_nxt;
      r_flush_cnt  <= w_flush_cnt_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_wd_cnt     <= w_wd_nxt;
      if (w_stalled && (w_wd_nxt == WD_LIMIT)) r_timeout <= 1'b1;
      if (w_stalled) r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  // Strobes are gated by reset directly so they drop the instant rst asserts.
  assign io_bus.stall        = rst ? w_stall  : 6'd0;
  assign io_bus.bubble       = rst & w_bubble;
  assign io_bus.flush        = rst & w_flush;
  assign io_bus.timeout      = r_timeout;
  assign io_bus.stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: driver pushes hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_pipe_stall_ctrl;
  localparam logic [5:0] S_STOP = 6'b011111;
  localparam logic [5:0] S_BBL  = 6'b000011;
  localparam logic [5:0] S_NONE = 6'b000000;

  typedef struct {
    logic [5:0] stall;
    logic       bubble;
    logic       flush;
    logic       timeout;
    int         cnt;      // -1 skips the counter comparison
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec   = 0;

  pipe_stall_ctrl_if #(.CNT_W(32)) bus ();

  pipe_stall_ctrl #(
    .FLUSH_CYCLES(3),
    .TIMEOUT     (8),
    .CNT_W       (32)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, vec, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic b, input logic s, input logic f,
                      input logic [5:0] es, input logic eb, input logic ef,
                      input logic eto, input int ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    bus.bbl_req   = b;
    bus.stop_req  = s;
    bus.flush_req = f;
    e.stall   = es;
    e.bubble  = eb;
    e.flush   = ef;
    e.timeout = eto;
    e.cnt     = ecnt;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("stall",   32'(bus.stall),   32'(e.stall));
      check("bubble",  32'(bus.bubble),  32'(e.bubble));
      check("flush",   32'(bus.flush),   32'(e.flush));
      check("timeout", 32'(bus.timeout), 32'(e.timeout));
      if (e.cnt >= 0) check("stall_cycles", bus.stall_cycles, 32'(e.cnt));
      vec++;
    end
  end

  initial begin
    bus.bbl_req   = 1'b0;
    bus.stop_req  = 1'b0;
    bus.flush_req = 1'b0;

    // Reset, then idle
    step(0, 0, 0, 0, S_NONE, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, S_NONE, 0, 0, 0, 0);

    // Bubble request for two cycles
    step(1, 1, 0, 0, S_BBL,  1, 0, 0, 0);
    step(1, 1, 0, 0, S_BBL,  1, 0, 0, 1);
    step(1, 0, 0, 0, S_NONE, 0, 0, 0, 2);

    // Stop five cycles, bubble request masked in cycle 2; RUN again on cycle 6
    step(1, 0, 1, 0, S_STOP, 0, 0, 0, 2);
    step(1, 1, 1, 0, S_STOP, 0, 0, 0, 3);
    step(1, 0, 1, 0, S_STOP, 0, 0, 0, 4);
    step(1, 0, 1, 0, S_STOP, 0, 0, 0, 5);
    step(1, 0, 1, 0, S_STOP, 0, 0, 0, 6);
    step(1, 1, 0, 0, S_BBL,  1, 0, 0, 7);
    step(1, 0, 0, 0, S_NONE, 0, 0, 0, 8);

    // Single flush lasts three cycles, bubble request ignored inside it
    step(1, 0, 0, 1, S_NONE, 0, 1, 0, 8);
    step(1, 1, 0, 0, S_NONE, 0, 1, 0, 8);
    step(1, 0, 0, 0, S_NONE, 0, 1, 0, 8);
    step(1, 0, 0, 0, S_NONE, 0, 0, 0, 8);

    // Second flush request in cycle 2 restarts the count
    step(1, 0, 0, 1, S_NONE, 0, 1, 0, 8);
    step(1, 0, 0, 1, S_NONE, 0, 1, 0, 8);
    step(1, 0, 0, 0, S_NONE, 0, 1, 0, 8);
    step(1, 0, 0, 0, S_NONE, 0, 1, 0, 8);
    step(1, 0, 0, 0, S_NONE, 0, 0, 0, 8);

    // Flush coincident with a four-cycle stop is deferred until release
    step(1, 0, 1, 1, S_STOP, 0, 0, 0, 8);
    step(1, 0, 1, 0, S_STOP, 0, 0, 0, 9);
    step(1, 0, 1, 0, S_STOP, 0, 0, 0, 10);
    step(1, 0, 1, 0, S_STOP, 0, 0, 0, 11);
    step(1, 0, 0, 0, S_NONE, 0, 1, 0, 12);
    step(1, 0, 0, 0, S_NONE, 0, 1, 0, 12);
    step(1, 0, 0, 0, S_NONE, 0, 1, 0, 12);
    step(1, 0, 0, 0, S_NONE, 0, 0, 0, 12);

    // Flush with bubble request, then reset aborts it mid-way
    step(1, 1, 0, 1, S_NONE, 0, 1, 0, 12);
    step(1, 0, 0, 0, S_NONE, 0, 1, 0, 12);
    step(0, 0, 0, 0, S_NONE, 0, 0, 0, 0);
    step(1, 0, 0, 0, S_NONE, 0, 0, 0, 0);
    step(1, 0, 0, 0, S_NONE, 0, 0, 0, 0);

    // 7 stalled, 1 idle, 7 stalled: watchdog never fires
    for (int i = 0; i < 7; i++) step(1, 0, 1, 0, S_STOP, 0, 0, 0, i);
    step(1, 0, 0, 0, S_NONE, 0, 0, 0, 7);
    for (int i = 0; i < 7; i++) step(1, 0, 1, 0, S_STOP, 0, 0, 0, 7 + i);
    step(1, 0, 0, 0, S_NONE, 0, 0, 0, 14);

    // 8 stalled cycles: timeout sets at the 8th edge and is sticky
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, S_STOP, 0, 0, 0, 14 + i);
    step(1, 0, 0, 0, S_NONE, 0, 0, 1, 22);
    step(1, 0, 0, 0, S_NONE, 0, 0, 1, 22);
    step(0, 0, 0, 0, S_NONE, 0, 0, 0, 0);
    step(1, 0, 0, 0, S_NONE, 0, 0, 0, 0);

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d want=0 pending expectations", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
